// File: rtl/videomem_fill.sv
// videomem_fill: fills a rectangular SDRAM region with an RGB565 test pattern
// through the controller's request/ack/give_next_data write port.
// Optional build macro VIDEOMEM_FILL_ERR_EN adds the sticky proto_err output.
module videomem_fill #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned REQ_PER_LINE = 8,
  parameter int unsigned NUM_LINES    = 720,
  parameter int unsigned LINE_SHIFT   = 12,
  parameter int unsigned READY_DELAY  = 4,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic              mem_clock,
  input  logic              reset_n,
  input  logic              mem_ready,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [15:0]       fill_color,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_req_ack,
  input  logic              give_next_data,
  output logic              wr_request,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              complete,
  output logic [15:0]       cur_line
`ifdef VIDEOMEM_FILL_ERR_EN
  ,
  output logic              proto_err
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, REQ, DATA, NEXT, DONE} state_e;

  localparam int unsigned BSH       = $clog2(BURST_LEN);
  localparam logic [4:0]  BEAT_LAST = 5'(BURST_LEN - 1);
  localparam logic [15:0] REQ_LAST  = 16'(REQ_PER_LINE - 1);
  localparam logic [15:0] LINE_END  = 16'(NUM_LINES);
  localparam logic [15:0] RDY_CNT   = 16'(READY_DELAY);

  state_e            state_q, state_d;
  logic              auto_q, auto_d;
  logic [15:0]       rdy_cnt_q, rdy_cnt_d;
  logic [15:0]       line_q, line_d;
  logic [15:0]       req_q, req_d;
  logic [4:0]        beat_q, beat_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       color_q, color_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              in_fill;
  logic              start_ok;
  logic [7:0]        word;
  logic [2:0]        bar_x;
  logic [15:0]       pix;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [15:0]       line,
                                                   input logic [15:0]       req);
    burst_addr = base + (ADDR_W'(line) << LINE_SHIFT) + (ADDR_W'(req) << BSH);
  endfunction

  assign in_fill    = (state_q == WAIT_RDY) || (state_q == REQ) ||
                      (state_q == DATA) || (state_q == NEXT);
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy       = in_fill;
  assign complete   = (state_q == DONE);
  assign cur_line   = line_q;
  assign wr_request = wr_req_q;
  assign wr_addr    = wr_addr_q;

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge mem_clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      auto_q    <= (AUTO_START != 0);
      rdy_cnt_q <= '0;
      line_q    <= '0;
      req_q     <= '0;
      beat_q    <= '0;
      mode_q    <= '0;
      color_q   <= '0;
      base_q    <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      rdy_cnt_q <= rdy_cnt_d;
      line_q    <= line_d;
      req_q     <= req_d;
      beat_q    <= beat_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      base_q    <= base_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Next-state, counter and registered request/address logic
  always_comb begin
    state_d   = state_q;
    auto_d    = 1'b0;
    rdy_cnt_d = rdy_cnt_q;
    line_d    = line_q;
    req_d     = req_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    color_d   = color_q;
    base_d    = base_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d   = WAIT_RDY;
          rdy_cnt_d = '0;
        end
      end
      WAIT_RDY: begin
        if (!mem_ready) begin
          rdy_cnt_d = '0;
        end else if (rdy_cnt_q == RDY_CNT) begin
          mode_d    = mode;
          color_d   = fill_color;
          base_d    = base_addr;
          line_d    = '0;
          req_d     = '0;
          wr_req_d  = 1'b1;
          wr_addr_d = burst_addr(base_addr, '0, '0);
          state_d   = REQ;
        end else begin
          rdy_cnt_d = rdy_cnt_q + 16'd1;
        end
      end
      REQ: begin
        if (mem_req_ack) begin
          wr_req_d = 1'b0;
          beat_d   = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (give_next_data) begin
          beat_d = beat_q + 5'd1;
          if (beat_q == BEAT_LAST) state_d = NEXT;
        end
      end
      NEXT: begin
        if (req_q == REQ_LAST) begin
          req_d  = '0;
          line_d = line_q + 16'd1;
        end else begin
          req_d = req_q + 16'd1;
        end
        if ((req_q == REQ_LAST) && (line_q + 16'd1 == LINE_END)) begin
          state_d = DONE;
        end else begin
          state_d   = REQ;
          wr_req_d  = 1'b1;
          wr_addr_d = burst_addr(base_q, line_d, req_d);
        end
      end
      DONE: begin
        if (start) begin
          state_d   = WAIT_RDY;
          rdy_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing mem_ready mid-fill abandons everything and re-arms the ready wait
    if (in_fill && !mem_ready) begin
      state_d   = WAIT_RDY;
      wr_req_d  = 1'b0;
      rdy_cnt_d = '0;
      line_d    = '0;
      req_d     = '0;
      beat_d    = '0;
    end
  end

  // Pattern generator: pixel from latched settings and current word/line
  always_comb begin
    word  = 8'(req_q << BSH) + 8'(beat_q);
    bar_x = word[7:5];
    pix   = color_q;
    unique case (mode_q)
      2'd0: pix = color_q;
      2'd1: pix = (bar_x == 3'd0) ? 16'hFFFF :
                  {bar_x[2] ? word[4:0] : 5'd0,
                   bar_x[1] ? {word[4:0], 1'b0} : 6'd0,
                   bar_x[0] ? word[4:0] : 5'd0};
      2'd2: pix = {word[4:0], word[5:0], word[4:0]};
      default: pix = (word[3] ^ line_q[3]) ? color_q : ~color_q;
    endcase
    wr_data = {(DATA_W/16){pix}};
  end

`ifdef VIDEOMEM_FILL_ERR_EN
  logic err_q, err_d;

  // Sticky flag for strobes arriving in the wrong state; accepted start clears it
  always_comb begin
    err_d = err_q | (mem_req_ack && (state_q != REQ)) |
                    (give_next_data && (state_q != DATA));
    if (start_ok) err_d = 1'b0;
  end

  // Protocol error register
  always_ff @(posedge mem_clock) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign proto_err = err_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
